// File: rtl/vga_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_mode_scheduler
// Brief    : Frame-synchronous test-pattern selector with registered RGB/sync.
//            Optional auto-cycle timer compiled in by macro VGA_SCHED_AUTO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_mode_scheduler #(
    parameter int AUTO_FRAMES = 120,
    parameter int CHECK_SHIFT = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic [3:0] sw_red,
    input  logic [3:0] sw_green,
    input  logic [3:0] sw_blue,
    input  logic       DE,
    input  logic [9:0] x_pixel,
    input  logic [9:0] y_pixel,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    output logic [3:0] r_port,
    output logic [3:0] g_port,
    output logic [3:0] b_port,
    output logic       h_sync,
    output logic       v_sync,
    output logic [1:0] mode
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        btn_q, vs_q;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_q, vso_q;

    logic        w_req, w_fb, w_manual_adv, w_auto_adv;
    logic [2:0]  w_bar;
    logic        w_check;

`ifdef VGA_SCHED_AUTO_EN
    localparam logic [7:0] c_auto_last = 8'(AUTO_FRAMES - 1);
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       w_unused;
    assign w_unused = ^{x_pixel, y_pixel};
`else
    logic       w_unused;
    assign w_unused = ^{x_pixel, y_pixel, auto_en, 8'(AUTO_FRAMES)};
`endif

    always_comb begin
        w_req        = btn_next & ~btn_q;
        w_fb         = vs_q & ~v_sync_in;
        // A pending request and a fresh edge in the boundary cycle merge into one step
        w_manual_adv = w_fb & (w_req | (state_q == PEND));

        state_d = state_q;
        if (w_fb) begin
            state_d = RUN;
        end else if (w_req) begin
            state_d = PEND;
        end

        w_auto_adv = 1'b0;
`ifdef VGA_SCHED_AUTO_EN
        frame_cnt_d = frame_cnt_q;
        if (w_fb) begin
            if (!auto_en) begin
                frame_cnt_d = 8'd0;
            end else if (frame_cnt_q == c_auto_last) begin
                w_auto_adv  = 1'b1;
                frame_cnt_d = 8'd0;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
            if (w_manual_adv) begin
                frame_cnt_d = 8'd0;
            end
        end
`endif

        mode_d = mode_q + {1'b0, (w_manual_adv | w_auto_adv)};

        w_bar   = x_pixel[8:6];
        w_check = x_pixel[CHECK_SHIFT] ^ y_pixel[CHECK_SHIFT];
        case (mode_q)
            2'd0:    rgb_d = {sw_red, sw_green, sw_blue};
            2'd1:    rgb_d = {{4{w_bar[0]}}, {4{w_bar[1]}}, {4{w_bar[2]}}};
            2'd2:    rgb_d = w_check ? 12'hFFF : 12'h000;
            default: rgb_d = {x_pixel[9:6], y_pixel[8:5], sw_blue};
        endcase
        if (!DE) begin
            rgb_d = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            btn_q       <= 1'b0;
            vs_q        <= 1'b1;
            mode_q      <= 2'd0;
            rgb_q       <= 12'h000;
            hs_q        <= 1'b1;
            vso_q       <= 1'b1;
`ifdef VGA_SCHED_AUTO_EN
            frame_cnt_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            btn_q       <= btn_next;
            vs_q        <= v_sync_in;
            mode_q      <= mode_d;
            rgb_q       <= rgb_d;
            hs_q        <= h_sync_in;
            vso_q       <= v_sync_in;
`ifdef VGA_SCHED_AUTO_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign r_port = rgb_q[11:8];
    assign g_port = rgb_q[7:4];
    assign b_port = rgb_q[3:0];
    assign h_sync = hs_q;
    assign v_sync = vso_q;
    assign mode   = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_mode_scheduler
// Brief    : Self-checking bench: pattern table, corner sequences, random run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_mode_scheduler;

    localparam int AF = 3;
    localparam int CS = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic [3:0] sw_red = 4'h0, sw_green = 4'h0, sw_blue = 4'h0;
    logic       de = 1'b0;
    logic [9:0] x = 10'd0, y = 10'd0;
    logic       hs_in = 1'b1, vs_in = 1'b1;
    logic [3:0] r_port, g_port, b_port;
    logic       h_sync, v_sync;
    logic [1:0] mode;

    vga_mode_scheduler #(.AUTO_FRAMES(AF), .CHECK_SHIFT(CS)) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .auto_en(auto_en),
        .sw_red(sw_red), .sw_green(sw_green), .sw_blue(sw_blue),
        .DE(de), .x_pixel(x), .y_pixel(y), .h_sync_in(hs_in), .v_sync_in(vs_in),
        .r_port(r_port), .g_port(g_port), .b_port(b_port),
        .h_sync(h_sync), .v_sync(v_sync), .mode(mode)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: displayed mode, outstanding request, boundaries since last advance
    int m_mode = 0, m_pend = 0, m_bnd = 0, m_pbtn = 0, m_pvs = 1;

    typedef struct {
        int         md;
        logic       d;
        int         px;
        int         py;
        logic [3:0] sr, sg, sb;
        logic [11:0] exp;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [11:0] pattern(int md, logic d, int px, int py,
                                            logic [3:0] sr, logic [3:0] sg, logic [3:0] sb);
        int bar;
        if (!d) return 12'h000;
        case (md)
            0: return {sr, sg, sb};
            1: begin
                bar = (px / 64) % 8;
                return {((bar % 2) != 0) ? 4'hF : 4'h0,
                        (((bar / 2) % 2) != 0) ? 4'hF : 4'h0,
                        (((bar / 4) % 2) != 0) ? 4'hF : 4'h0};
            end
            2: return ((((px >> CS) + (py >> CS)) % 2) == 1) ? 12'hFFF : 12'h000;
            default: return {4'((px / 64) % 16), 4'((py / 32) % 16), sb};
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int req, fb, adv;
        logic [11:0] e_rgb;
        logic e_hs, e_vs;
        req   = (btn_next && m_pbtn == 0) ? 1 : 0;
        fb    = (m_pvs == 1 && !vs_in) ? 1 : 0;
        e_rgb = pattern(m_mode, de, int'(x), int'(y), sw_red, sw_green, sw_blue);
        e_hs  = hs_in;
        e_vs  = vs_in;
        if (fb != 0) begin
            adv = (m_pend != 0 || req != 0) ? 1 : 0;
`ifdef VGA_SCHED_AUTO_EN
            if (auto_en) begin
                m_bnd++;
                if (m_bnd >= AF) adv = 1;
            end else begin
                m_bnd = 0;
            end
`endif
            if (adv != 0) begin
                m_mode = (m_mode + 1) % 4;
                m_bnd  = 0;
            end
            m_pend = 0;
        end else if (req != 0) begin
            m_pend = 1;
        end
        m_pbtn = btn_next ? 1 : 0;
        m_pvs  = vs_in ? 1 : 0;
        @(posedge clk);
        #1;
        check("rgb", int'({r_port, g_port, b_port}), int'(e_rgb));
        check("sync", int'({h_sync, v_sync}), int'({e_hs, e_vs}));
        check("mode", int'(mode), m_mode);
    endtask

    task automatic run(input int n, input logic vs);
        for (int i = 0; i < n; i++) begin
            de    = 1'($urandom);
            x     = 10'($urandom);
            y     = 10'($urandom);
            hs_in = 1'($urandom);
            vs_in = vs;
            step();
        end
    endtask

    task automatic boundary();
        btn_next = 1'b0;
        run(2, 1'b0);
        run(3, 1'b1);
    endtask

    task automatic press();
        btn_next = 1'b1;
        run(1, 1'b1);
        btn_next = 1'b0;
        run(2, 1'b1);
    endtask

    task automatic do_reset();
        btn_next = 1'b0;
        vs_in    = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("rst_rgb", int'({r_port, g_port, b_port}), 0);
        check("rst_sync", int'({h_sync, v_sync}), 3);
        check("rst_mode", int'(mode), 0);
        m_mode = 0; m_pend = 0; m_bnd = 0; m_pbtn = 0; m_pvs = 1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_mode(input int md);
        for (int k = 0; k < 8 && m_mode != md; k++) begin
            press();
            boundary();
        end
    endtask

    initial begin
        int m0;
        tbl[0]  = '{0, 1'b1,   10,  10, 4'h3, 4'h5, 4'h9, 12'h359};
        tbl[1]  = '{0, 1'b0,   10,  10, 4'h3, 4'h5, 4'h9, 12'h000};
        tbl[2]  = '{1, 1'b1,   64,   5, 4'h1, 4'h2, 4'h3, 12'hF00};
        tbl[3]  = '{1, 1'b1,  127,   5, 4'h1, 4'h2, 4'h3, 12'hF00};
        tbl[4]  = '{1, 1'b1,    0,   5, 4'h1, 4'h2, 4'h3, 12'h000};
        tbl[5]  = '{1, 1'b1,  128,   5, 4'h1, 4'h2, 4'h3, 12'h0F0};
        tbl[6]  = '{1, 1'b1,  448,   5, 4'h1, 4'h2, 4'h3, 12'hFFF};
        tbl[7]  = '{1, 1'b0,   64,   5, 4'h1, 4'h2, 4'h3, 12'h000};
        tbl[8]  = '{2, 1'b1,   32,   0, 4'h1, 4'h2, 4'h3, 12'hFFF};
        tbl[9]  = '{2, 1'b1,   32,  32, 4'h1, 4'h2, 4'h3, 12'h000};
        tbl[10] = '{2, 1'b1,    0,   0, 4'h1, 4'h2, 4'h3, 12'h000};
        tbl[11] = '{2, 1'b0,   32,   0, 4'h1, 4'h2, 4'h3, 12'h000};
        tbl[12] = '{3, 1'b1, 1023, 511, 4'h1, 4'h2, 4'h9, 12'hFF9};
        tbl[13] = '{3, 1'b1,  320,  64, 4'h1, 4'h2, 4'hA, 12'h52A};
        tbl[14] = '{3, 1'b0,  320,  64, 4'h1, 4'h2, 4'hA, 12'h000};

        do_reset();
        run(5, 1'b1);

        // Pattern table
        for (int i = 0; i < 15; i++) begin
            set_mode(tbl[i].md);
            check("vec_mode", int'(mode), tbl[i].md);
            de = tbl[i].d; x = 10'(tbl[i].px); y = 10'(tbl[i].py);
            sw_red = tbl[i].sr; sw_green = tbl[i].sg; sw_blue = tbl[i].sb;
            hs_in = 1'b0; vs_in = 1'b1;
            step();
            check($sformatf("vec%0d", i), int'({r_port, g_port, b_port}), int'(tbl[i].exp));
        end

        // Mid-line reset, then deferred change
        run(7, 1'b1);
        do_reset();
        run(100, 1'b1);
        press();
        run(20, 1'b1);
        check("defer_hold", int'(mode), 0);
        run(1, 1'b0);
        check("defer_adv", int'(mode), 1);
        run(1, 1'b0);
        run(40, 1'b1);
        check("defer_frame", int'(mode), 1);

        // Three presses in one frame coalesce
        m0 = m_mode;
        press(); press(); press();
        boundary();
        check("coalesce", int'(mode), (m0 + 1) % 4);

        // Press coincident with the boundary cycle
        m0 = m_mode;
        btn_next = 1'b1;
        run(1, 1'b0);
        btn_next = 1'b0;
        run(1, 1'b0);
        check("coincident", int'(mode), (m0 + 1) % 4);
        run(3, 1'b1);

        // Wrap 3 -> 0
        set_mode(3);
        press();
        boundary();
        check("wrap", int'(mode), 0);

        // Stuck-high v_sync keeps request pending
        press();
        run(200, 1'b1);
        check("stuck_hold", int'(mode), 0);
        boundary();
        check("stuck_adv", int'(mode), 1);

        // Reset drops a pending request
        press();
        do_reset();
        boundary();
        check("rst_drop", int'(mode), 0);

`ifdef VGA_SCHED_AUTO_EN
        auto_en = 1'b1;
        boundary(); boundary();
        check("auto_2", int'(mode), 0);
        boundary();
        check("auto_3", int'(mode), 1);
        boundary();
        press();
        boundary();
        check("auto_manual", int'(mode), 2);
        boundary(); boundary();
        check("auto_restart", int'(mode), 2);
        boundary();
        check("auto_next", int'(mode), 3);
        auto_en = 1'b0;
        for (int i = 0; i < 6; i++) boundary();
        check("auto_off", int'(mode), 3);
`else
        auto_en = 1'b1;
        for (int i = 0; i < 10; i++) boundary();
        check("noauto", int'(mode), 0);
`endif

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            btn_next = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 29) == 0) vs_in = ~vs_in;
            de       = 1'($urandom);
            x        = 10'($urandom);
            y        = 10'($urandom);
            hs_in    = 1'($urandom);
            sw_red   = 4'($urandom);
            sw_green = 4'($urandom);
            sw_blue  = 4'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
